// File: rtl/seg_bcd_converter_pkg.sv
// Shared types and constants for the seven-segment BCD converter.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [3:0] SEG_MINUS   = 4'hF;
    localparam logic [3:0] SEG_POS     = 4'h0;
    localparam logic [3:0] SEG_BLANK   = 4'hE;
    localparam int         SHIFT_STEPS = 8;

endpackage

// File: rtl/seg_bcd_converter_if.sv
// Request/display bundle between the processor's output port and the converter.
interface seg_bcd_converter_if;

    logic [7:0] data_in;
    logic       load;
    logic       busy;
    logic       done;
    logic [3:0] seven_seg_sign;
    logic [3:0] seven_seg_digit_1;
    logic [3:0] seven_seg_digit_2;
    logic [3:0] seven_seg_digit_3;

    modport master (
        output data_in, load,
        input  busy, done, seven_seg_sign,
        input  seven_seg_digit_1, seven_seg_digit_2, seven_seg_digit_3
    );

    modport slave (
        input  data_in, load,
        output busy, done, seven_seg_sign,
        output seven_seg_digit_1, seven_seg_digit_2, seven_seg_digit_3
    );

endinterface

// File: rtl/seg_bcd_converter_bcd_add3.sv
// Double-dabble nibble correction: values of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Add-3 correction
    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end else begin
            o_nib = i_nib;
        end
    end

endmodule

// File: rtl/seg_bcd_converter.sv
// Iterative 8-bit binary to sign + 3-digit BCD converter, one double-dabble step per clock.
// Optional leading-zero blanking when SEG_BLANK_EN is defined.
module seg_bcd_converter
    import seg_pkg::*;
#(
    parameter logic SIGNED    = 1'b1,
    parameter logic AUTO_LOAD = 1'b0
) (
    input  logic                clk,
    input  logic                resetN,
    seg_bcd_converter_if.slave  bus
);

    state_t      r_state;
    logic [3:0]  r_step;
    logic [11:0] r_bcd;
    logic [7:0]  r_mag;
    logic        r_sign;
    logic [7:0]  r_last;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_seg_sign;
    logic [3:0]  r_dig1;
    logic [3:0]  r_dig2;
    logic [3:0]  r_dig3;

    logic        w_start;
    logic        w_neg;
    logic [7:0]  w_abs;
    logic [11:0] w_adj;
    logic [3:0]  w_dig1;
    logic [3:0]  w_dig2;

    assign w_start = bus.load | (AUTO_LOAD & (bus.data_in != r_last));
    assign w_neg   = SIGNED & bus.data_in[7];
    // -128 wraps to 8'h80, which is exactly the unsigned magnitude 128
    assign w_abs   = w_neg ? (8'd0 - bus.data_in) : bus.data_in;

    bcd_add3 u_add3_hund (.i_nib(r_bcd[11:8]), .o_nib(w_adj[11:8]));
    bcd_add3 u_add3_tens (.i_nib(r_bcd[7:4]),  .o_nib(w_adj[7:4]));
    bcd_add3 u_add3_unit (.i_nib(r_bcd[3:0]),  .o_nib(w_adj[3:0]));

`ifdef SEG_BLANK_EN
    assign w_dig1 = (r_bcd[11:8] == 4'd0) ? SEG_BLANK : r_bcd[11:8];
    assign w_dig2 = (r_bcd[11:4] == 8'd0) ? SEG_BLANK : r_bcd[7:4];
`else
    assign w_dig1 = r_bcd[11:8];
    assign w_dig2 = r_bcd[7:4];
`endif

    // Conversion FSM with shift register and atomically updated display registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= IDLE;
            r_step     <= 4'd0;
            r_bcd      <= 12'd0;
            r_mag      <= 8'd0;
            r_sign     <= 1'b0;
            r_last     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_seg_sign <= 4'h0;
            r_dig1     <= 4'h0;
            r_dig2     <= 4'h0;
            r_dig3     <= 4'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_sign  <= w_neg;
                        r_mag   <= w_abs;
                        r_last  <= bus.data_in;
                        r_bcd   <= 12'd0;
                        r_step  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_mag} <= {w_adj, r_mag} << 5'd1;
                    r_step         <= r_step + 4'd1;
                    if (r_step == 4'(SHIFT_STEPS - 1)) begin
                        r_state <= UPDATE;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                UPDATE: begin
                    r_seg_sign <= r_sign ? SEG_MINUS : SEG_POS;
                    r_dig1     <= w_dig1;
                    r_dig2     <= w_dig2;
                    r_dig3     <= r_bcd[3:0];
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy              = r_busy;
    assign bus.done              = r_done;
    assign bus.seven_seg_sign    = r_seg_sign;
    assign bus.seven_seg_digit_1 = r_dig1;
    assign bus.seven_seg_digit_2 = r_dig2;
    assign bus.seven_seg_digit_3 = r_dig3;

endmodule

// File: tb/tb_seg_bcd_converter.sv
// Scoreboard bench: a signed manual-load instance and an unsigned auto-load instance.
`timescale 1ns/1ps
module tb_seg_bcd_converter;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    seg_bcd_converter_if a_if ();
    seg_bcd_converter_if b_if ();

    seg_bcd_converter #(.SIGNED(1'b1), .AUTO_LOAD(1'b0)) u_dut_s (
        .clk(clk), .resetN(resetN), .bus(a_if)
    );
    seg_bcd_converter #(.SIGNED(1'b0), .AUTO_LOAD(1'b1)) u_dut_u (
        .clk(clk), .resetN(resetN), .bus(b_if)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb_a[$];
    logic [15:0] sb_b[$];
    logic [15:0] hold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, packed as {sign, d1, d2, d3}
    function automatic logic [15:0] model(input logic [7:0] v, input bit sgn);
        int         mag;
        bit         neg;
        logic [3:0] d1, d2, d3, s;
        neg = sgn && v[7];
        mag = neg ? (256 - int'(v)) : int'(v);
        d1  = 4'(mag / 100);
        d2  = 4'((mag / 10) % 10);
        d3  = 4'(mag % 10);
        s   = neg ? 4'hF : 4'h0;
`ifdef SEG_BLANK_EN
        if (mag < 100) d1 = 4'hE;
        if (mag < 10)  d2 = 4'hE;
`endif
        return {s, d1, d2, d3};
    endfunction

    function automatic logic [15:0] disp_a();
        return {a_if.seven_seg_sign, a_if.seven_seg_digit_1, a_if.seven_seg_digit_2, a_if.seven_seg_digit_3};
    endfunction

    function automatic logic [15:0] disp_b();
        return {b_if.seven_seg_sign, b_if.seven_seg_digit_1, b_if.seven_seg_digit_2, b_if.seven_seg_digit_3};
    endfunction

    always @(negedge clk) begin
        if (resetN === 1'b1 && a_if.done === 1'b1) begin
            check_eq("a_done_expected", 32'(sb_a.size() > 0), 32'd1);
            if (sb_a.size() > 0) check_eq("a_display", 32'(disp_a()), 32'(sb_a.pop_front()));
        end
        if (resetN === 1'b1 && b_if.done === 1'b1) begin
            check_eq("b_done_expected", 32'(sb_b.size() > 0), 32'd1);
            if (sb_b.size() > 0) check_eq("b_display", 32'(disp_b()), 32'(sb_b.pop_front()));
        end
    end

    task automatic wait_done(input bit sel, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = sel ? b_if.done : a_if.done;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic run_a(input logic [7:0] v);
        a_if.data_in = v;
        a_if.load    = 1'b1;
        sb_a.push_back(model(v, 1'b1));
        @(posedge clk); #1;
        a_if.load = 1'b0;
        wait_done(1'b0, "a_done_timeout");
    endtask

    task automatic run_b(input logic [7:0] v, input logic ld);
        b_if.data_in = v;
        b_if.load    = ld;
        sb_b.push_back(model(v, 1'b0));
        @(posedge clk); #1;
        b_if.load = 1'b0;
        wait_done(1'b1, "b_done_timeout");
    endtask

    initial begin
        a_if.data_in = 8'h00; a_if.load = 1'b0;
        b_if.data_in = 8'h00; b_if.load = 1'b0;
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_a_busy", 32'(a_if.busy), 32'd0);
        check_eq("rst_a_done", 32'(a_if.done), 32'd0);
        check_eq("rst_a_disp", 32'(disp_a()), 32'd0);
        check_eq("rst_b_disp", 32'(disp_b()), 32'd0);
        resetN = 1'b1;
        @(posedge clk); #1;

        // 127 with cycle-exact busy/done/hold checks
        hold = disp_a();
        a_if.data_in = 8'h7F;
        a_if.load    = 1'b1;
        sb_a.push_back(model(8'h7F, 1'b1));
        @(posedge clk); #1;
        a_if.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check_eq("a127_busy", 32'(a_if.busy), 32'd1);
            check_eq("a127_done_low", 32'(a_if.done), 32'd0);
            check_eq("a127_hold", 32'(disp_a()), 32'(hold));
            @(posedge clk); #1;
        end
        check_eq("a127_done_pulse", 32'(a_if.done), 32'd1);
        check_eq("a127_busy_in_done", 32'(a_if.busy), 32'd0);
        @(posedge clk); #1;
        check_eq("a127_done_single", 32'(a_if.done), 32'd0);

        run_a(8'h80);
        run_a(8'hFF);
        run_a(8'h00);

        // Unsigned / auto-load instance
        run_b(8'h80, 1'b1);
        run_b(8'hFF, 1'b0);
        run_b(8'd5,  1'b0);
        run_b(8'd40, 1'b0);
        run_b(8'd0,  1'b0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("b_no_retrigger", 32'(b_if.busy), 32'd0);

        // Load during busy is ignored; held into the done cycle it restarts
        @(posedge clk); #1;
        a_if.data_in = 8'd25;
        a_if.load    = 1'b1;
        sb_a.push_back(model(8'd25, 1'b1));
        @(posedge clk); #1;
        a_if.load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_if.data_in = 8'd99;
        a_if.load    = 1'b1;
        sb_a.push_back(model(8'd99, 1'b1));
        repeat (5) @(posedge clk);
        #1;
        check_eq("a_busy_load_done", 32'(a_if.done), 32'd1);
        @(posedge clk); #1;
        a_if.load = 1'b0;
        check_eq("a_restart_busy", 32'(a_if.busy), 32'd1);
        wait_done(1'b0, "a99_done_timeout");

        // Reset at step 5 aborts with no done
        @(posedge clk); #1;
        a_if.data_in = 8'd200;
        a_if.load    = 1'b1;
        sb_a.push_back(model(8'd200, 1'b1));
        @(posedge clk); #1;
        a_if.load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetN = 1'b0;
        sb_a.delete();
        #1;
        check_eq("mid_rst_busy", 32'(a_if.busy), 32'd0);
        check_eq("mid_rst_done", 32'(a_if.done), 32'd0);
        check_eq("mid_rst_disp_a", 32'(disp_a()), 32'd0);
        check_eq("mid_rst_disp_b", 32'(disp_b()), 32'd0);
        @(posedge clk); #1;
        resetN = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("post_rst_idle", 32'(a_if.busy), 32'd0);
        check_eq("post_rst_disp", 32'(disp_a()), 32'd0);
        run_a(8'd42);

        repeat (3) @(posedge clk);
        #1;
        check_eq("a_sb_drained", 32'(sb_a.size()), 32'd0);
        check_eq("b_sb_drained", 32'(sb_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
